// File: rtl/md_controller.sv
`default_nettype none
// ============================================================================
// Module      : md_controller
// Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
//               Results are computed when the operation is accepted. They are
//               held in pending registers and committed to HI/LO when the
//               fixed 5-cycle (mult) or 10-cycle (div) busy window expires.
// Revision    : 1.0 - initial release
// ============================================================================
module md_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_E,
    input  logic [1:0]  MDop_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        MTHI_E,
    input  logic        MTLO_E,
    output logic        Busy,
    output logic        MDstall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;
    localparam logic [3:0] c_MULT_CYC = 4'd5;
    localparam logic [3:0] c_DIV_CYC  = 4'd10;
    localparam logic [31:0] c_INT_MIN = 32'h8000_0000;
    localparam logic [31:0] c_NEG_ONE = 32'hFFFF_FFFF;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic signed [63:0] w_a_sext;
    logic signed [63:0] w_b_sext;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic        [31:0] w_div_b;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;

    assign w_a_sext = $signed({{32{A_E[31]}}, A_E});
    assign w_b_sext = $signed({{32{B_E[31]}}, B_E});
    assign w_prod_s = w_a_sext * w_b_sext;
    assign w_prod_u = {32'd0, A_E} * {32'd0, B_E};

    // The divider never sees zero or the INT_MIN/-1 overflow pair; those
    // cases are resolved explicitly below and the divider output is unused.
    assign w_div_zero = (B_E == 32'd0);
    assign w_div_ovf  = (A_E == c_INT_MIN) && (B_E == c_NEG_ONE);
    assign w_div_b    = (w_div_zero || w_div_ovf) ? 32'd1 : B_E;
    assign w_quo_s    = $signed(A_E) / $signed(w_div_b);
    assign w_rem_s    = $signed(A_E) % $signed(w_div_b);
    assign w_quo_u    = A_E / w_div_b;
    assign w_rem_u    = A_E % w_div_b;

    // Select the result for the requested operation; divide by zero keeps
    // the current HI/LO so the eventual commit leaves them unchanged.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (MDop_E)
            2'b00: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'b01: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'b10: begin
                if (w_div_ovf) begin
                    w_res_hi = 32'd0;
                    w_res_lo = c_INT_MIN;
                end else if (!w_div_zero) begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
            end
            default: begin
                if (!w_div_zero) begin
                    w_res_hi = w_rem_u;
                    w_res_lo = w_quo_u;
                end
            end
        endcase
    end

    // Control FSM, cycle counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 4'd0;
                    if (Start_E) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_cnt     <= MDop_E[1] ? c_DIV_CYC : c_MULT_CYC;
                        r_state   <= c_RUN;
                    end else begin
                        if (MTHI_E) begin
                            r_hi <= A_E;
                        end
                        if (MTLO_E) begin
                            r_lo <= A_E;
                        end
                    end
                end
                c_RUN: begin
                    if (r_cnt <= 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= 4'd0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Busy    = (r_state == c_RUN);
    assign MDstall = Start_E | Busy;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_controller
// Description : Directed scoreboard bench for md_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_controller;

    logic        clk;
    logic        reset;
    logic        Start_E;
    logic [1:0]  MDop_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        MTHI_E;
    logic        MTLO_E;
    logic        Busy;
    logic        MDstall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_controller dut (
        .clk     (clk),
        .reset   (reset),
        .Start_E (Start_E),
        .MDop_E  (MDop_E),
        .A_E     (A_E),
        .B_E     (B_E),
        .MTHI_E  (MTHI_E),
        .MTLO_E  (MTLO_E),
        .Busy    (Busy),
        .MDstall (MDstall),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge with the unit idle; leaves at the falling edge
    // of the first idle cycle after the operation.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc, input logic mtlo_with_start, input logic mthi_in_run);
        exp_t e;
        int   n;
        e.hi = ehi; e.lo = elo; e.cycles = cyc;
        sb.push_back(e);
        Start_E = 1'b1; MDop_E = op; A_E = a; B_E = b; MTLO_E = mtlo_with_start;
        #1;
        check({tag, "_stall"}, {31'd0, MDstall}, 32'd1);
        @(negedge clk);
        Start_E = 1'b0; MTLO_E = 1'b0;
        A_E = 32'hDEAD_BEEF; B_E = 32'h0BAD_F00D;
        if (mthi_in_run) MTHI_E = 1'b1;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            check({tag, "_run_hi"}, HI, m_hi);
            check({tag, "_run_lo"}, LO, m_lo);
            n++;
            @(negedge clk);
            MTHI_E = 1'b0;
        end
        MTHI_E = 1'b0;
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_busy_cycles"}, n, e.cycles);
            check({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
            check({tag, "_hi"}, HI, e.hi);
            check({tag, "_lo"}, LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic do_mt(input string tag, input logic hi_en, input logic lo_en, input logic [31:0] d);
        MTHI_E = hi_en; MTLO_E = lo_en; A_E = d;
        @(negedge clk);
        MTHI_E = 1'b0; MTLO_E = 1'b0; A_E = 32'h0;
        if (hi_en) m_hi = d;
        if (lo_en) m_lo = d;
        check({tag, "_hi"}, HI, m_hi);
        check({tag, "_lo"}, LO, m_lo);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int  n;
        logic saw_bad;
        checks = 0; failures = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1; Start_E = 1'b0; MDop_E = 2'b00; A_E = 32'd0; B_E = 32'd0;
        MTHI_E = 1'b0; MTLO_E = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_stall", {31'd0, MDstall}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("mult_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 1'b0);
        do_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0, 1'b0);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0);
        do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b0, 1'b0);
        do_op("divu_big_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10, 1'b0, 1'b0);
        do_mt("mthi_11", 1'b1, 1'b0, 32'h11);
        do_mt("mtlo_22", 1'b0, 1'b1, 32'h22);
        do_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0, 1'b0);
        do_mt("mthi_1234", 1'b1, 1'b0, 32'h1234);
        do_op("multu_mthi_run", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0, 1'b1);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, 1'b0);
        do_op("mult_mtlo_drop", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1'b1, 1'b0);
        do_mt("mt_both", 1'b1, 1'b1, 32'hABCD);

        // Reset pulsed asynchronously in the third busy cycle of mult 7x6.
        Start_E = 1'b1; MDop_E = 2'b00; A_E = 32'd7; B_E = 32'd6;
        @(negedge clk);
        Start_E = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", {31'd0, Busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        #1 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        saw_bad = 1'b0;
        for (n = 0; n < 12; n++) begin
            @(negedge clk);
            if (LO !== 32'd0 || Busy !== 1'b0) saw_bad = 1'b1;
        end
        check("abort_lo_stays_0", {31'd0, saw_bad}, 32'd0);
        check("abort_lo_final", LO, 32'd0);

        do_op("mult_7x6_fresh", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
